// File: rtl/seg_glyph_pkg.sv
// rtl/seg_glyph_pkg.sv - glyph codes and 7-segment pattern table
// Shared glyph code width, named codes and the code-to-segment lookup.
package seg_glyph_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] G_A     = 4'hA;
  localparam logic [CODE_W-1:0] G_C     = 4'hB;
  localparam logic [CODE_W-1:0] G_L     = 4'hC;
  localparam logic [CODE_W-1:0] G_P     = 4'hD;
  localparam logic [CODE_W-1:0] G_DASH  = 4'hE;
  localparam logic [CODE_W-1:0] G_BLANK = 4'hF;

  // Active-low pattern ordered {g,f,e,d,c,b,a}; 0 doubles as O and 5 as S.
  function automatic logic [6:0] glyph(input logic [CODE_W-1:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      G_A:     pat = 7'b0001000;
      G_C:     pat = 7'b1000110;
      G_L:     pat = 7'b1000111;
      G_P:     pat = 7'b0001100;
      G_DASH:  pat = 7'b0111111;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// rtl/seg_prescaler.sv - free-running modulo-DIV counter with terminal-count tick
// Counts 0..DIV-1 while run is high; clr forces the count back to 0.
module seg_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(DIV - 1));
  assign tick   = run && at_end;

  // Next count: clear has priority, otherwise wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_msg_scroller.sv
// rtl/seg_msg_scroller.sv - scrolling message driver for multiplexed 7-segment digits
// Holds the message, the scroll offset and the scan slot, and registers seg/an.
module seg_msg_scroller
  import seg_glyph_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 16,
  parameter int SCROLL_DIV = 25_000_000,
  parameter int SCAN_DIV   = 50_000,
  localparam int POS_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [MSG_LEN*CODE_W-1:0]  msg_in,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       step,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
  output logic [POS_W-1:0]           pos,
  output logic                       wrap
);

  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Wide enough for pos + digit index with MSG_LEN up to 256.
  localparam int SUM_W  = 9;

  logic [MSG_LEN*CODE_W-1:0] msg_q, msg_d;
  logic [POS_W-1:0]          pos_q, pos_d;
  logic                      wrap_q, wrap_d;
  logic [SCAN_W-1:0]         scan_idx_q, scan_idx_d;
  logic [6:0]                seg_q;
  logic [NUM_DIGITS-1:0]     an_q;

  logic                      scan_tick;
  logic                      scroll_tick;
  logic                      move;
  logic [SUM_W-1:0]          char_sum;
  logic [SUM_W-1:0]          char_idx;
  logic [CODE_W-1:0]         char_code;

  seg_prescaler #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .run   (1'b1),
    .tick  (scan_tick)
  );

  // Scroll timer stops and clears whenever auto-scroll is off; a load restarts it.
  seg_prescaler #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!en || load),
    .run   (en),
    .tick  (scroll_tick)
  );

  // A load swallows any coincident step or scroll tick.
  assign move = !load && (en ? scroll_tick : step);

  // Message capture and offset update with explicit compare-and-wrap.
  always_comb begin
    msg_d  = msg_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (load) begin
      msg_d = msg_in;
      pos_d = '0;
    end else if (move) begin
      if (!dir) begin
        if (pos_q == POS_W'(MSG_LEN - 1)) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = POS_W'(MSG_LEN - 1);
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  // Scan slot advances on each scan tick and wraps after the last digit.
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_tick) begin
      scan_idx_d = (scan_idx_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // Character index (pos + k) mod MSG_LEN; k < MSG_LEN so one subtraction suffices.
  always_comb begin
    char_sum = SUM_W'(pos_q) + SUM_W'(scan_idx_q);
    char_idx = char_sum;
    if (char_sum >= SUM_W'(MSG_LEN)) begin
      char_idx = char_sum - SUM_W'(MSG_LEN);
    end
  end

  // Select the glyph code for the active digit.
  always_comb begin
    char_code = G_BLANK;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (char_idx == SUM_W'(i)) begin
        char_code = msg_q[i*CODE_W +: CODE_W];
      end
    end
  end

  // State and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q      <= {MSG_LEN{G_BLANK}};
      pos_q      <= '0;
      wrap_q     <= 1'b0;
      scan_idx_q <= '0;
      seg_q      <= 7'h7F;
      an_q       <= '1;
    end else begin
      msg_q      <= msg_d;
      pos_q      <= pos_d;
      wrap_q     <= wrap_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= glyph(char_code);
      an_q       <= ~(NUM_DIGITS'(1) << scan_idx_q);
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_msg_scroller.sv
// tb/tb_seg_msg_scroller.sv - directed self-checking bench for seg_msg_scroller
module tb_seg_msg_scroller;

  localparam int NUM_DIGITS = 4;
  localparam int MSG_LEN    = 6;
  localparam int SCROLL_DIV = 16;
  localparam int SCAN_DIV   = 4;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [23:0] msg_in;
  logic        en;
  logic        dir;
  logic        step;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [2:0]  pos;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  seg_msg_scroller #(
    .NUM_DIGITS (NUM_DIGITS),
    .MSG_LEN    (MSG_LEN),
    .SCROLL_DIV (SCROLL_DIV),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .msg_in (msg_in),
    .en     (en),
    .dir    (dir),
    .step   (step),
    .seg    (seg),
    .an     (an),
    .pos    (pos),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cycles(1);
    step = 1'b0;
  endtask

  task automatic wait_digit(input int k, input logic [6:0] exp_seg, input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk);
      #1;
      if (an === ~(4'b0001 << k)) found = 1'b1;
    end
    check({tag, "_found"}, 32'(found), 32'd1);
    check(tag, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    msg_in = '0;
    en     = 1'b0;
    dir    = 1'b0;
    step   = 1'b0;

    // 1. reset values, then blank scan sequence
    #23;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      cycles(1);
      check($sformatf("scan_an_%0d", c), 32'(an), 32'(~(4'b0001 << (((c - 1) / 4) % 4)) & 4'hF));
      check($sformatf("scan_seg_%0d", c), 32'(seg), 32'h7F);
    end
    check("scan_pos", 32'(pos), 32'd0);

    // 2. load "POLA-S" = D,0,C,A,E,5 with char0 in the low nibble
    msg_in = 24'h5EAC0D;
    load   = 1'b1;
    cycles(1);
    load   = 1'b0;
    check("load_pos", 32'(pos), 32'd0);
    check("load_wrap", 32'(wrap), 32'd0);
    wait_digit(0, 7'b0001100, "p2_d0_P");
    wait_digit(1, 7'b1000000, "p2_d1_O");
    wait_digit(2, 7'b1000111, "p2_d2_L");
    wait_digit(3, 7'b0001000, "p2_d3_A");

    // 3. manual steps forward through the wrap, then one step backward
    for (int i = 1; i <= 6; i++) begin
      pulse_step();
      check($sformatf("step_pos_%0d", i), 32'(pos), 32'(i % 6));
      check($sformatf("step_wrap_%0d", i), 32'(wrap), 32'(i == 6));
    end
    cycles(1);
    check("wrap_drop", 32'(wrap), 32'd0);
    dir = 1'b1;
    pulse_step();
    check("back_pos", 32'(pos), 32'd5);
    check("back_wrap", 32'(wrap), 32'd1);

    // 4. auto-scroll forward from pos 5; step ignored while scrolling
    dir = 1'b0;
    en  = 1'b1;
    cycles(15);
    check("as_hold_pos", 32'(pos), 32'd5);
    cycles(1);
    check("as_wrap_pos", 32'(pos), 32'd0);
    check("as_wrap", 32'(wrap), 32'd1);
    cycles(4);
    pulse_step();
    cycles(11);
    check("as_step_ign_pos", 32'(pos), 32'd1);
    check("as_step_ign_wrap", 32'(wrap), 32'd0);
    cycles(48);
    check("as_pos4", 32'(pos), 32'd4);
    en = 1'b0;
    wait_digit(0, 7'b0111111, "p4_d0_dash");
    wait_digit(1, 7'b0010010, "p4_d1_S");
    wait_digit(2, 7'b0001100, "p4_d2_P");
    wait_digit(3, 7'b1000000, "p4_d3_O");
    check("freeze_pos", 32'(pos), 32'd4);

    // 5. load on the tick that would have wrapped 5 -> 0
    en = 1'b1;
    cycles(16);
    check("p5_pos5", 32'(pos), 32'd5);
    cycles(15);
    msg_in = 24'h654321;
    load   = 1'b1;
    cycles(1);
    load   = 1'b0;
    check("p5_load_pos", 32'(pos), 32'd0);
    check("p5_load_wrap", 32'(wrap), 32'd0);
    cycles(15);
    check("p5_hold_pos", 32'(pos), 32'd0);
    cycles(1);
    check("p5_next_pos", 32'(pos), 32'd1);
    en = 1'b0;
    wait_digit(0, 7'b0100100, "p5_d0_2");
    wait_digit(1, 7'b0110000, "p5_d1_3");
    wait_digit(3, 7'b0010010, "p5_d3_5");

    // 6. asynchronous reset in the middle of a scroll period at pos 3
    en = 1'b1;
    cycles(32);
    check("p6_pos3", 32'(pos), 32'd3);
    check("p6_seg_lit", 32'(seg != 7'h7F), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("p6_seg", 32'(seg), 32'h7F);
    check("p6_an", 32'(an), 32'hF);
    check("p6_pos", 32'(pos), 32'd0);
    check("p6_wrap", 32'(wrap), 32'd0);
    en = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(6);
    check("p6_blank_msg", 32'(seg), 32'h7F);
    check("p6_pos_after", 32'(pos), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
